// File: rtl/usb_pkg.sv
// Shared packet type, PID encodings and FSM state encoding for the USB-style
// protocol engine, encoder and decoder.
package usb_pkg;

    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;

    typedef struct packed {
        logic [3:0]  pid;
        logic [3:0]  endp;
        logic [6:0]  addr;
        logic [63:0] data;
    } pkt_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TOKEN,
        ST_DATA,
        ST_WAIT_HS,
        ST_WAIT_DATA,
        ST_SEND_HS
    } state_t;

    function automatic pkt_t make_pkt(input logic [3:0] pid, input logic [3:0] endp,
                                      input logic [6:0] addr, input logic [63:0] data);
        pkt_t p;
        p.pid  = pid;
        p.endp = endp;
        p.addr = addr;
        p.data = data;
        return p;
    endfunction

endpackage

// File: rtl/timeout_counter.sv
// Response-wait timer: counts while enabled, flags expiry on the TIMEOUT-th
// enabled cycle after a clear.
module timeout_counter #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TERM = CW'(TIMEOUT - 1);

    logic [CW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != TERM)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = enable && (count_q == TERM);

endmodule

// File: rtl/protocol_fsm.sv
// Host-side transaction sequencer: issues tokens/data/handshakes to the
// encoder, interprets decoder packets, and retries failed attempts.
//
// state        | meaning
// ST_IDLE      | waiting for out_trans / in_trans
// ST_TOKEN     | OUT or IN token sent, waiting for pkt_sent
// ST_DATA      | DATA0 with payload sent, waiting for pkt_sent
// ST_WAIT_HS   | OUT: waiting for device handshake
// ST_WAIT_DATA | IN: waiting for device DATA0
// ST_SEND_HS   | IN: ACK/NAK sent, waiting for pkt_sent
module protocol_fsm
    import usb_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR     = 7'd5,
    parameter logic [3:0] DEV_ENDP     = 4'd4,
    parameter int         TIMEOUT      = 255,
    parameter int         MAX_ATTEMPTS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        out_trans,
    input  logic        in_trans,
    input  logic [63:0] data_to_device,
    output pkt_t        pkt_out,
    output logic        pkt_send,
    input  logic        pkt_sent,
    input  pkt_t        pkt_in,
    input  logic        pkt_rcvd,
    input  logic        pkt_crc_ok,
    output logic [63:0] data_from_device,
    output logic        success,
    output logic        failure
);

    localparam int AW = $clog2(MAX_ATTEMPTS + 1);

    state_t        state_q, state_d;
    logic          is_out_q, is_out_d;
    logic [63:0]   payload_q, payload_d;
    logic [AW-1:0] attempt_q, attempt_d;
    logic [3:0]    hs_pid_q, hs_pid_d;
    logic [63:0]   rx_data_q, rx_data_d;
    pkt_t          pkt_out_q, pkt_out_d;
    logic          pkt_send_q, pkt_send_d;
    logic          success_q, success_d;
    logic          failure_q, failure_d;
    logic          attempt_fail;
    logic          waiting;
    logic          expired;
    logic          unused_pkt_fields;

    assign waiting = (state_q == ST_WAIT_HS) || (state_q == ST_WAIT_DATA);
    assign unused_pkt_fields = ^{pkt_in.endp, pkt_in.addr};

    // Clearing whenever not waiting guarantees a zero count on every entry.
    timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (!waiting),
        .enable  (waiting),
        .expired (expired)
    );

    always_comb begin
        state_d      = state_q;
        is_out_d     = is_out_q;
        payload_d    = payload_q;
        attempt_d    = attempt_q;
        hs_pid_d     = hs_pid_q;
        rx_data_d    = rx_data_q;
        pkt_out_d    = pkt_out_q;
        pkt_send_d   = 1'b0;
        success_d    = 1'b0;
        failure_d    = 1'b0;
        attempt_fail = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (out_trans || in_trans) begin
                    is_out_d   = out_trans;
                    payload_d  = data_to_device;
                    attempt_d  = '0;
                    state_d    = ST_TOKEN;
                    pkt_send_d = 1'b1;
                    pkt_out_d  = make_pkt(out_trans ? PID_OUT : PID_IN, DEV_ENDP, DEV_ADDR, 64'd0);
                end
            end
            ST_TOKEN: begin
                if (pkt_sent) begin
                    if (is_out_q) begin
                        state_d    = ST_DATA;
                        pkt_send_d = 1'b1;
                        pkt_out_d  = make_pkt(PID_DATA0, 4'd0, 7'd0, payload_q);
                    end else begin
                        state_d = ST_WAIT_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (pkt_sent) begin
                    state_d = ST_WAIT_HS;
                end
            end
            ST_WAIT_HS: begin
                if (pkt_rcvd) begin
                    if (pkt_crc_ok && (pkt_in.pid == PID_ACK)) begin
                        success_d = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        attempt_fail = 1'b1;
                    end
                end else if (expired) begin
                    attempt_fail = 1'b1;
                end
            end
            ST_WAIT_DATA: begin
                if (pkt_rcvd) begin
                    if (pkt_crc_ok && (pkt_in.pid == PID_DATA0)) begin
                        rx_data_d = pkt_in.data;
                        hs_pid_d  = PID_ACK;
                    end else begin
                        hs_pid_d  = PID_NAK;
                    end
                    state_d    = ST_SEND_HS;
                    pkt_send_d = 1'b1;
                    pkt_out_d  = make_pkt(hs_pid_d, 4'd0, 7'd0, 64'd0);
                end else if (expired) begin
                    attempt_fail = 1'b1;
                end
            end
            ST_SEND_HS: begin
                if (pkt_sent) begin
                    if (hs_pid_q == PID_ACK) begin
                        success_d = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        attempt_fail = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (attempt_fail) begin
            attempt_d = attempt_q + 1'b1;
            if (attempt_d == AW'(MAX_ATTEMPTS)) begin
                failure_d = 1'b1;
                state_d   = ST_IDLE;
            end else begin
                state_d    = ST_TOKEN;
                pkt_send_d = 1'b1;
                pkt_out_d  = make_pkt(is_out_q ? PID_OUT : PID_IN, DEV_ENDP, DEV_ADDR, 64'd0);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            is_out_q   <= 1'b0;
            payload_q  <= '0;
            attempt_q  <= '0;
            hs_pid_q   <= '0;
            rx_data_q  <= '0;
            pkt_out_q  <= '0;
            pkt_send_q <= 1'b0;
            success_q  <= 1'b0;
            failure_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            is_out_q   <= is_out_d;
            payload_q  <= payload_d;
            attempt_q  <= attempt_d;
            hs_pid_q   <= hs_pid_d;
            rx_data_q  <= rx_data_d;
            pkt_out_q  <= pkt_out_d;
            pkt_send_q <= pkt_send_d;
            success_q  <= success_d;
            failure_q  <= failure_d;
        end
    end

    assign pkt_out          = pkt_out_q;
    assign pkt_send         = pkt_send_q;
    assign data_from_device = rx_data_q;
    assign success          = success_q;
    assign failure          = failure_q;

endmodule
